// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one read at a time to instruction memory and
// hands the returned word, with its address, to decode through a one-entry slot.
// Latency: request in cycle N, response in N+k, slot valid from the following edge.
// Backpressure: no request issues unless the slot is empty or drains this cycle;
// a full slot holds all outputs stable until if_ready.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   pc_address / pc_enable_n      current PC in, active-low advance strobe out
//   redirect                      flush: control loads a new PC this cycle
//   imem_req_valid/ready, imem_addr   memory read request handshake
//   imem_resp_valid, imem_resp_data   memory read response
//   if_valid/ready, if_instr, if_pc, if_fault   slot towards decode
module instruction_fetch #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [XLEN-1:0] pc_address,
   output logic            pc_enable_n,
   input  logic            redirect,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            if_fault
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,   // free to issue
      S_WAIT = 2'd1,   // one request outstanding
      S_DROP = 2'd2    // outstanding response belongs to a flushed path
   } state_t;

   state_t          state;
   logic [XLEN-1:0] req_pc;

   logic slot_free;
   logic aligned;
   logic can_issue;
   logic req_fire;
   logic fault_load;
   logic resp_load;

   // The slot counts as free when it is empty or being drained this cycle,
   // which gives back-to-back fetches without a bubble.
   assign slot_free  = !if_valid || if_ready;
   assign aligned    = (pc_address[1:0] == 2'b00);
   assign can_issue  = reset_n && (state == S_REQ) && slot_free && !redirect;

   assign imem_req_valid = can_issue && aligned;
   assign imem_addr      = pc_address;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign pc_enable_n    = !req_fire;

   // A misaligned PC never reaches memory; it turns into a fault slot instead
   // and the PC is not advanced, so control must redirect away from it.
   assign fault_load = can_issue && !aligned;
   assign resp_load  = (state == S_WAIT) && imem_resp_valid && !redirect;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= S_REQ;
         req_pc   <= '0;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
         if_fault <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (req_fire) begin
                  req_pc <= pc_address;
                  state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               // A response always retires the request, flushed or not.
               if (imem_resp_valid)
                  state <= S_REQ;
               else if (redirect)
                  state <= S_DROP;
            end
            S_DROP: begin
               // Leave only once the stale response has been swallowed; a
               // further redirect while waiting changes nothing here.
               if (imem_resp_valid)
                  state <= S_REQ;
            end
            default: state <= S_REQ;
         endcase

         if (redirect) begin
            if_valid <= 1'b0;
            if_fault <= 1'b0;
         end else if (resp_load) begin
            if_valid <= 1'b1;
            if_instr <= imem_resp_data;
            if_pc    <= req_pc;
            if_fault <= 1'b0;
         end else if (fault_load) begin
            if_valid <= 1'b1;
            if_instr <= '0;
            if_pc    <= pc_address;
            if_fault <= 1'b1;
         end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter XLEN, 32, width of addresses and of the fetched instruction word.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 pc_address  input  XLEN  current address from program_counter.
REQ-005 pc_enable_n  output  1  active-low advance strobe to program_counter.
REQ-006 redirect  input  1  flush; control is loading a new PC this cycle.
REQ-007 imem_req_valid  output  1  instruction-memory read request valid.
REQ-008 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-009 imem_addr  output  XLEN  request address.
REQ-010 imem_resp_valid  input  1  read data valid; never in the same cycle the request is accepted.
REQ-011 imem_resp_data  input  XLEN  read data.
REQ-012 if_valid  output  1  output slot holds a fetched instruction.
REQ-013 if_ready  input  1  decode consumes the slot this cycle.
REQ-014 if_instr  output  XLEN  fetched instruction.
REQ-015 if_pc  output  XLEN  address of if_instr.
REQ-016 if_fault  output  1  misaligned-fetch marker for the slot.

Function
REQ-017 The FSM SHALL have exactly three states: REQ (may issue), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-018 At most one memory request SHALL be outstanding; the output slot is one entry deep.
REQ-019 "slot_free" SHALL mean !if_valid || (if_valid && if_ready) in the current cycle.
REQ-020 In REQ, imem_req_valid SHALL equal slot_free && !redirect && pc_address[1:0]==0, with imem_addr = pc_address combinationally.
REQ-021 On an accepted request (imem_req_valid && imem_req_ready), the block SHALL capture pc_address into an internal req_pc, drive pc_enable_n=0 for that cycle only, and enter WAIT.
REQ-022 pc_enable_n SHALL be 1 in every cycle without an accepted request or fault-slot load.
REQ-023 In REQ with slot_free, !redirect and pc_address[1:0]!=0, no request SHALL issue; the slot SHALL be loaded next edge with if_pc=pc_address, if_instr=0, if_fault=1; pc_enable_n SHALL be 1; the state SHALL remain REQ.
REQ-024 In WAIT on imem_resp_valid with !redirect, the slot SHALL load if_instr=imem_resp_data, if_pc=req_pc, if_fault=0, and the state SHALL return to REQ; zero-bubble: next request may issue the following cycle.
REQ-025 A loaded slot SHALL hold all outputs stable while if_valid && !if_ready.
REQ-026 if_valid SHALL clear on if_valid && if_ready unless the slot reloads in the same cycle.
REQ-027 redirect SHALL, at the next edge, clear if_valid, if_fault, and discard any response arriving that cycle; a request SHALL NOT be issued in a redirect cycle.
REQ-028 redirect in WAIT without imem_resp_valid SHALL move the FSM to DROP; with imem_resp_valid it SHALL move to REQ.
REQ-029 In DROP, imem_req_valid SHALL be 0 and the first imem_resp_valid SHALL be discarded, returning to REQ; redirect in DROP SHALL keep DROP.
REQ-030 redirect in REQ SHALL leave the state REQ.
REQ-031 imem_resp_valid in REQ SHALL be ignored.

Reset
REQ-032 While reset_n is low at a rising edge: state<=REQ, if_valid<=0, if_instr<=0, if_pc<=0, if_fault<=0, req_pc<=0.
REQ-033 During any cycle in which reset_n is low, imem_req_valid SHALL be 0 and pc_enable_n SHALL be 1.
REQ-034 Reset mid-WAIT or mid-DROP SHALL abandon the outstanding request; the memory shares reset_n and returns no response for it.

Verification
REQ-035 Reset then pc_address=0x00000000, imem_req_ready=1, response 0x00000013 one cycle later, if_ready=1 -> pc_enable_n low one cycle; if_valid=1, if_instr=0x00000013, if_pc=0x00000000.
REQ-036 Backpressure: slot full, if_ready=0 for 3 cycles -> imem_req_valid=0, outputs held; if_ready=1 -> request issued the same cycle.
REQ-037 imem_req_ready=0 for 4 cycles -> imem_req_valid held, imem_addr stable, pc_enable_n=1 throughout.
REQ-038 redirect while in WAIT, response 0xDEADBEEF two cycles later -> response discarded, if_valid stays 0, next request issued the cycle after the response.
REQ-039 pc_address=0x00000102 -> no imem request; slot if_pc=0x00000102, if_fault=1, if_instr=0.
REQ-040 reset_n low for one cycle during WAIT -> all outputs at reset values next cycle; imem_req_valid resumes following cycle.
